// File: rtl/bf16_add_scheduler.sv
// bf16_add_scheduler: round-robin front end that time-shares one bfloat16
// adder between NREQ requesters. A single operation is in flight at a time;
// a watchdog turns a silent adder into an all-ones result with resp_err set.
module bf16_add_scheduler #(
    parameter int NREQ    = 4,
    parameter int W       = 16,
    parameter int TIMEOUT = 16
) (
    input  logic              clock,
    input  logic              nreset,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic [NREQ-1:0]   resp_valid,
    input  logic [NREQ-1:0]   resp_ready,
    output logic [W-1:0]      resp_sum,
    output logic              resp_err,
    output logic [W-1:0]      add_a,
    output logic [W-1:0]      add_b,
    output logic              add_start,
    input  logic [W-1:0]      add_sum,
    input  logic              add_done
);

    localparam int PW = $clog2(NREQ);
    localparam int CW = $clog2(TIMEOUT + 1);
    // The counter value held on the last WAIT cycle; the abort makes it reach TIMEOUT-1.
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 2);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [PW-1:0]   rr_ptr;
    logic [PW-1:0]   grant;
    logic [PW-1:0]   pick;
    logic            any_valid;
    logic [CW-1:0]   cnt;
    logic            timeout_hit;

    // Position k steps after base, wrapping at NREQ (NREQ need not be a power of two).
    function automatic logic [PW-1:0] rot_idx(input logic [PW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NREQ) s -= NREQ;
        return PW'(s);
    endfunction

    assign timeout_hit = (cnt == CNT_LAST);

    // Round-robin search: the lowest rotation offset from rr_ptr with a valid request wins.
    always_comb begin
        pick      = '0;
        any_valid = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_valid[rot_idx(rr_ptr, k)]) begin
                pick      = rot_idx(rr_ptr, k);
                any_valid = 1'b1;
            end
        end
    end

    // Next-state and handshake strobes; req_ready is masked while reset is asserted.
    always_comb begin
        state_nxt  = state;
        req_ready  = '0;
        resp_valid = '0;
        add_start  = 1'b0;
        case (state)
            IDLE: begin
                if (any_valid) begin
                    req_ready[pick] = nreset;
                    state_nxt       = ISSUE;
                end
            end
            ISSUE: begin
                add_start = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (add_done || timeout_hit) state_nxt = RESP;
            end
            RESP: begin
                resp_valid[grant] = 1'b1;
                if (resp_ready[grant]) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) state <= IDLE;
        else         state <= state_nxt;
    end

    // Grant/pointer bookkeeping, operand capture, watchdog and result registers.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            rr_ptr   <= '0;
            grant    <= '0;
            cnt      <= '0;
            add_a    <= '0;
            add_b    <= '0;
            resp_sum <= '0;
            resp_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        grant  <= pick;
                        rr_ptr <= rot_idx(pick, 1);
                        add_a  <= req_a[int'(pick)*W +: W];
                        add_b  <= req_b[int'(pick)*W +: W];
                    end
                end
                ISSUE: cnt <= '0;
                WAIT: begin
                    if (add_done) begin
                        resp_sum <= add_sum;
                        resp_err <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (timeout_hit) begin
                            resp_sum <= '1;
                            resp_err <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bf16_add_scheduler.sv
// Testbench for bf16_add_scheduler: behavioural adder with programmable
// latency, scoreboard of expected responses filled at accept time and
// drained at the response handshake, plus directed latency/boundary checks.
module tb_bf16_add_scheduler;

    localparam int NREQ    = 4;
    localparam int W       = 16;
    localparam int TIMEOUT = 16;

    logic              clock = 1'b0;
    logic              nreset = 1'b0;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a = '0;
    logic [NREQ*W-1:0] req_b = '0;
    logic [NREQ-1:0]   resp_valid;
    logic [NREQ-1:0]   resp_ready = '1;
    logic [W-1:0]      resp_sum;
    logic              resp_err;
    logic [W-1:0]      add_a;
    logic [W-1:0]      add_b;
    logic              add_start;
    logic [W-1:0]      add_sum;
    logic              add_done;

    logic              model_done = 1'b0;
    logic              spur_done = 1'b0;
    logic [W-1:0]      model_sum = '0;
    int                pend = 0;
    int                lat = 3;
    bit                never = 1'b0;
    int                cyc = 0;

    int                n_vec = 0;
    int                n_err = 0;

    typedef struct {
        int         idx;
        logic [15:0] sum;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   grant_log[$];

    assign add_done = model_done | spur_done;
    assign add_sum  = model_sum;

    bf16_add_scheduler #(.NREQ(NREQ), .W(W), .TIMEOUT(TIMEOUT)) dut (
        .clock(clock), .nreset(nreset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_sum(resp_sum), .resp_err(resp_err),
        .add_a(add_a), .add_b(add_b), .add_start(add_start),
        .add_sum(add_sum), .add_done(add_done)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Truncating bf16 add, valid for positive normal operands.
    function automatic logic [15:0] bf16_add(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] x, y;
        logic [7:0]  ex, ey, d;
        logic [8:0]  mx, my, s;
        if (a[14:0] >= b[14:0]) begin x = a; y = b; end
        else begin x = b; y = a; end
        ex = x[14:7];
        ey = y[14:7];
        d  = ex - ey;
        mx = {2'b01, x[6:0]};
        my = {2'b01, y[6:0]};
        my = (d > 8'd8) ? 9'd0 : (my >> d);
        s  = mx + my;
        if (s[8]) return {1'b0, ex + 8'd1, s[7:1]};
        return {1'b0, ex, s[6:0]};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Adder model: answers lat cycles after add_start, or never.
    always @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            pend       <= 0;
            model_done <= 1'b0;
        end else if (add_start && !never) begin
            model_sum <= bf16_add(add_a, add_b);
            if (lat == 1) begin
                model_done <= 1'b1;
                pend       <= 0;
            end else begin
                model_done <= 1'b0;
                pend       <= lat - 1;
            end
        end else if (pend > 0) begin
            pend       <= pend - 1;
            model_done <= (pend == 1);
        end else begin
            model_done <= 1'b0;
        end
    end

    // Monitor: one-hot strobes, scoreboard push on accept, pop on response handshake.
    always @(negedge clock) begin
        exp_t e;
        int   idx;
        if (nreset) begin
            check_eq("req_ready_onehot", 32'($onehot0(req_ready)), 32'd1);
            check_eq("resp_valid_onehot", 32'($onehot0(resp_valid)), 32'd1);
            if (|(req_ready & req_valid)) begin
                idx = 0;
                for (int i = 0; i < NREQ; i++) if (req_ready[i]) idx = i;
                e.idx = idx;
                if (never || lat > TIMEOUT - 1) begin
                    e.sum = 16'hFFFF;
                    e.err = 1'b1;
                end else begin
                    e.sum = bf16_add(req_a[idx*W +: W], req_b[idx*W +: W]);
                    e.err = 1'b0;
                end
                sb.push_back(e);
                grant_log.push_back(idx);
            end
            if (|(resp_valid & resp_ready)) begin
                check_eq("sb_nonempty", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check_eq("resp_who", 32'(resp_valid), 32'(1 << e.idx));
                    check_eq("resp_sum", 32'(resp_sum), 32'(e.sum));
                    check_eq("resp_err", 32'(resp_err), 32'(e.err));
                end
            end
        end
    end

    task automatic drive_req(input int i, input logic [15:0] a, input logic [15:0] b);
        @(posedge clock); #1;
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
        req_valid[i]    = 1'b1;
    endtask

    task automatic wait_accept(input int i, output int t);
        t = -1;
        for (int k = 0; k < 64; k++) begin
            @(negedge clock);
            if (req_ready[i]) begin t = cyc; break; end
        end
        check_eq("accept_seen", 32'(t >= 0), 32'd1);
    endtask

    task automatic drop_req(input int i);
        @(posedge clock); #1;
        req_valid[i] = 1'b0;
    endtask

    task automatic wait_resp(output int t);
        t = -1;
        for (int k = 0; k < 64; k++) begin
            @(negedge clock);
            if (|resp_valid) begin t = cyc; break; end
        end
        check_eq("resp_seen", 32'(t >= 0), 32'd1);
    endtask

    initial begin
        int t, r;
        logic [15:0] held;

        // Reset values
        repeat (2) @(negedge clock);
        check_eq("rst_req_ready", 32'(req_ready), 32'd0);
        check_eq("rst_resp_valid", 32'(resp_valid), 32'd0);
        check_eq("rst_add_start", 32'(add_start), 32'd0);
        check_eq("rst_resp_err", 32'(resp_err), 32'd0);
        check_eq("rst_resp_sum", 32'(resp_sum), 32'd0);
        check_eq("rst_add_a", 32'(add_a), 32'd0);
        check_eq("rst_add_b", 32'(add_b), 32'd0);
        @(posedge clock); #1 nreset = 1'b1;

        // Single request, adder latency 3
        lat = 3;
        drive_req(0, 16'h3F80, 16'h4000);
        wait_accept(0, t);
        drop_req(0);
        @(negedge clock);
        check_eq("single_start_cyc", 32'(cyc), 32'(t + 1));
        check_eq("single_add_start", 32'(add_start), 32'd1);
        check_eq("single_add_a", 32'(add_a), 32'h3F80);
        check_eq("single_add_b", 32'(add_b), 32'h4000);
        wait_resp(r);
        check_eq("single_resp_cyc", 32'(r), 32'(t + 5));
        check_eq("single_resp_valid", 32'(resp_valid), 32'h1);
        check_eq("single_resp_sum", 32'(resp_sum), 32'h4040);
        check_eq("single_resp_err", 32'(resp_err), 32'd0);
        repeat (4) @(negedge clock);

        // Fairness after a fresh reset (rr_ptr back at 0)
        @(posedge clock); #2 nreset = 1'b0;
        #2 nreset = 1'b1;
        lat = 1;
        grant_log.delete();
        @(posedge clock); #1;
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*W +: W] = 16'h3F80 + 16'(i << 7);
            req_b[i*W +: W] = 16'h4000 + 16'(i * 5);
        end
        req_valid = '1;
        for (int k = 0; k < 100 && grant_log.size() < 5; k++) @(negedge clock);
        @(posedge clock); #1 req_valid = '0;
        check_eq("fair_count", 32'(grant_log.size() >= 5), 32'd1);
        for (int k = 0; k < 5 && k < grant_log.size(); k++)
            check_eq("fair_order", 32'(grant_log[k]), 32'(k % NREQ));
        repeat (8) @(negedge clock);

        // Response backpressure on requester 1 while requester 0 waits
        lat = 2;
        resp_ready = 4'b1101;
        req_a[0*W +: W] = 16'h4100; req_b[0*W +: W] = 16'h3F80;
        drive_req(1, 16'h4040, 16'h4040);
        req_valid[0] = 1'b1;
        wait_accept(1, t);
        drop_req(1);
        wait_resp(r);
        check_eq("bp_resp_valid", 32'(resp_valid), 32'h2);
        held = resp_sum;
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            check_eq("bp_hold_valid", 32'(resp_valid), 32'h2);
            check_eq("bp_hold_sum", 32'(resp_sum), 32'(held));
            check_eq("bp_no_ready", 32'(req_ready), 32'd0);
        end
        @(posedge clock); #1 resp_ready = '1;
        @(negedge clock);
        @(negedge clock);
        check_eq("bp_idle_next", 32'(req_ready), 32'h1);
        drop_req(0);
        repeat (8) @(negedge clock);

        // Watchdog: adder never answers
        never = 1'b1;
        drive_req(2, 16'h4000, 16'h4000);
        wait_accept(2, t);
        drop_req(2);
        wait_resp(r);
        check_eq("to_resp_cyc", 32'(r), 32'(t + 17));
        check_eq("to_resp_valid", 32'(resp_valid), 32'h4);
        check_eq("to_resp_sum", 32'(resp_sum), 32'hFFFF);
        check_eq("to_resp_err", 32'(resp_err), 32'd1);
        repeat (3) @(negedge clock);

        // add_done on the final WAIT cycle still wins
        never = 1'b0;
        lat = TIMEOUT - 1;
        drive_req(3, 16'h4080, 16'h3F80);
        wait_accept(3, t);
        drop_req(3);
        wait_resp(r);
        check_eq("late_resp_cyc", 32'(r), 32'(t + 17));
        check_eq("late_resp_valid", 32'(resp_valid), 32'h8);
        check_eq("late_resp_err", 32'(resp_err), 32'd0);
        check_eq("late_resp_sum", 32'(resp_sum), 32'(bf16_add(16'h4080, 16'h3F80)));
        repeat (3) @(negedge clock);

        // Reset while WAIT is pending; rr_ptr must return to 0
        never = 1'b1;
        drive_req(1, 16'h40A0, 16'h4000);
        wait_accept(1, t);
        drop_req(1);
        repeat (3) @(negedge clock);
        @(posedge clock); #2;
        nreset = 1'b0;
        sb.delete();
        #1;
        check_eq("arst_add_start", 32'(add_start), 32'd0);
        check_eq("arst_resp_valid", 32'(resp_valid), 32'd0);
        check_eq("arst_add_a", 32'(add_a), 32'd0);
        check_eq("arst_add_b", 32'(add_b), 32'd0);
        check_eq("arst_resp_sum", 32'(resp_sum), 32'd0);
        check_eq("arst_resp_err", 32'(resp_err), 32'd0);
        check_eq("arst_req_ready", 32'(req_ready), 32'd0);
        @(posedge clock); #1;
        nreset = 1'b1;
        never = 1'b0;
        lat = 3;
        req_a[0*W +: W] = 16'h3F80; req_b[0*W +: W] = 16'h3F80;
        req_a[2*W +: W] = 16'h4000; req_b[2*W +: W] = 16'h4100;
        req_valid = 4'b0101;
        @(negedge clock);
        check_eq("arst_first_grant", 32'(req_ready), 32'h1);
        drop_req(0);
        wait_accept(2, t);
        drop_req(2);
        repeat (10) @(negedge clock);

        // Spurious add_done in IDLE
        @(posedge clock); #1 spur_done = 1'b1;
        @(posedge clock); #1 spur_done = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            check_eq("spur_no_resp", 32'(resp_valid), 32'd0);
            check_eq("spur_no_start", 32'(add_start), 32'd0);
        end
        lat = 2;
        drive_req(1, 16'h4000, 16'h3F80);
        wait_accept(1, t);
        drop_req(1);
        wait_resp(r);
        check_eq("spur_after_cyc", 32'(r), 32'(t + 4));
        repeat (10) @(negedge clock);

        check_eq("sb_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
